// File: rtl/cpu_pkg.sv
// Shared definitions for the lab CPU: opcode encodings, instruction field
// positions and the fetch-state encoding.
package cpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  // Field positions within the 8-bit instruction byte
  localparam int OPC_LSB = 6;
  localparam int RS_LSB  = 4;
  localparam int RT_LSB  = 2;
  localparam int RD_LSB  = 0;
  localparam int JOFF_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  function automatic logic [7:0] sext6(input logic [5:0] v);
    return {{2{v[5]}}, v};
  endfunction

  function automatic logic [7:0] sext2(input logic [1:0] v);
    return {{6{v[1]}}, v};
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: splits an instruction byte into its
// fields and forms the sign-extended immediate.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [7:0] ir,
  output logic [1:0] opcode,
  output logic [1:0] rs,
  output logic [1:0] rt,
  output logic [1:0] rd,
  output logic [7:0] imm
);

  assign opcode = ir[OPC_LSB +: 2];
  assign rs     = ir[RS_LSB  +: 2];
  assign rt     = ir[RT_LSB  +: 2];
  assign rd     = ir[RD_LSB  +: 2];

  // Jumps carry a 6-bit offset; everything else a 2-bit immediate in rd
  assign imm = (opcode == OP_JMP) ? sext6(ir[JOFF_W-1:0]) : sext2(ir[1:0]);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, loads the instruction register from imem,
// resolves jumps locally and honours stall/redirect from execute.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int         PC_LIMIT = 32,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  input  logic       stall,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_target,
  output logic       instr_valid,
  output logic [1:0] opcode,
  output logic [1:0] rs,
  output logic [1:0] rt,
  output logic [1:0] rd,
  output logic [7:0] imm,
  output logic       halted
);

  localparam logic [31:0] LIMIT = PC_LIMIT;

  fetch_state_t state_reg, state_next;
  logic [7:0]   pc_reg, pc_next;
  logic [7:0]   ir_reg, ir_next;
  logic         valid_reg, valid_next;
  logic [7:0]   pc_cand;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      ir_reg    <= 8'h00;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    valid_next = valid_reg;
    pc_cand    = pc_reg;
    case (state_reg)
      IDLE: begin
        state_next = RUN;
        valid_next = 1'b0;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_cand    = redirect_target;
          valid_next = 1'b0;
        end else if (!stall) begin
          ir_next    = imem_data;
          valid_next = 1'b1;
          if (imem_data[OPC_LSB +: 2] == OP_JMP)
            pc_cand = pc_reg + 8'd1 + sext6(imem_data[JOFF_W-1:0]);
          else
            pc_cand = pc_reg + 8'd1;
        end
        // Leaving program space freezes PC and IR at their current values
        if ({24'd0, pc_cand} >= LIMIT) begin
          state_next = HALT;
          valid_next = 1'b0;
          ir_next    = ir_reg;
        end else begin
          pc_next = pc_cand;
        end
      end
      HALT: valid_next = 1'b0;
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  assign imem_addr   = pc_reg;
  assign instr_valid = valid_reg;
  assign halted      = (state_reg == HALT);

  instr_decode u_decode (
    .ir     (ir_reg),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .imm    (imm)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios then random
// stall/redirect/reset traffic, checked against a behavioural fetch model.
module tb_instr_fetch_unit;

  localparam int LIMIT = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       stall = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_target = 8'h00;
  logic       instr_valid;
  logic [1:0] opcode, rs, rt, rd;
  logic [7:0] imm;
  logic       halted;

  int checks = 0;
  int errors = 0;
  int txn = 0;

  typedef struct {
    int pc;
    int ir;
    bit v;
    bit h;
  } exp_t;
  exp_t exp_q[$];

  // Behavioural model state: st 0=idle, 1=running, 2=halted
  int m_pc, m_ir, m_st;
  bit m_v;
  bit prev_reset = 1'b1;
  int halt_cycles = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [7:0] a);
    case (a)
      8'd0: return 8'h47;
      8'd1: return 8'h59;
      8'd2: return 8'h7D;
      8'd3: return 8'h71;
      8'd4: return 8'h5D;
      8'd5: return 8'h59;
      8'd6: return 8'h6D;
      8'd7: return 8'h71;
      8'd8: return 8'hC3;
      default: return 8'h00;
    endcase
  endfunction

  assign imem_data = rom(imem_addr);

  instr_fetch_unit #(.PC_LIMIT(LIMIT), .RESET_PC(8'h00)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .opcode          (opcode),
    .rs              (rs),
    .rt              (rt),
    .rd              (rd),
    .imm             (imm),
    .halted          (halted)
  );

  function automatic int signed_field(input int v, input int bits);
    int half = 1 << (bits - 1);
    return (v >= half) ? v - (1 << bits) : v;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit rv, input int tgt);
    int np, nir, byte_v;
    bit nv;
    if (r) begin
      m_pc = 0; m_ir = 0; m_v = 0; m_st = 0;
      return;
    end
    if (m_st == 0) begin
      m_st = 1;
      return;
    end
    if (m_st == 2) return;
    np = m_pc; nir = m_ir; nv = m_v;
    if (rv) begin
      np = tgt; nv = 0;
    end else if (!s) begin
      byte_v = int'(rom(8'(m_pc)));
      nir = byte_v; nv = 1;
      if (byte_v / 64 == 3) np = (m_pc + 1 + signed_field(byte_v % 64, 6) + 256) % 256;
      else np = (m_pc + 1) % 256;
    end
    if (np >= LIMIT) begin
      m_st = 2; m_v = 0;
    end else begin
      m_pc = np; m_ir = nir; m_v = nv;
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit rv, input int tgt);
    exp_t e;
    @(negedge clk);
    reset = r; stall = s; redirect_valid = rv; redirect_target = 8'(tgt);
    if (r && !prev_reset) begin
      #1;
      chk("async_rst_pc", int'(imem_addr), 0);
      chk("async_rst_valid", int'(instr_valid), 0);
      chk("async_rst_halted", int'(halted), 0);
    end
    prev_reset = r;
    model_step(r, s, rv, tgt);
    e.pc = m_pc; e.ir = m_ir; e.v = m_v; e.h = (m_st == 2);
    exp_q.push_back(e);
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge
  always @(posedge clk) begin
    exp_t e;
    int ir_e, imm_e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      txn++;
      $display("txn %0d pc=%02h valid=%0d halted=%0d op=%0d imm=%02h", txn, imem_addr,
               instr_valid, halted, opcode, imm);
      chk("pc", int'(imem_addr), e.pc);
      chk("instr_valid", int'(instr_valid), int'(e.v));
      chk("halted", int'(halted), int'(e.h));
      if (e.v) begin
        ir_e = e.ir;
        if (ir_e / 64 == 3) imm_e = (signed_field(ir_e % 64, 6) + 256) % 256;
        else imm_e = (signed_field(ir_e % 4, 2) + 256) % 256;
        chk("opcode", int'(opcode), ir_e / 64);
        chk("rs", int'(rs), (ir_e / 16) % 4);
        chk("rt", int'(rt), (ir_e / 4) % 4);
        chk("rd", int'(rd), ir_e % 4);
        chk("imm", int'(imm), imm_e);
      end
    end
  end

  initial begin
    m_pc = 0; m_ir = 0; m_v = 0; m_st = 0;
    // Reset, release, stall at PC=2 for three cycles, resume
    repeat (3) cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);
    repeat (3) cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    // Redirect to 5 wins over stall, then run through the jump to halt
    cycle(0, 1, 1, 8'h05);
    repeat (30) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 8'h02);
    cycle(0, 1, 0, 0);
    // Reset mid-run at PC=4
    repeat (2) cycle(1, 0, 0, 0);
    repeat (5) cycle(0, 0, 0, 0);
    repeat (2) cycle(1, 0, 0, 0);
    // Redirect straight out of program space
    repeat (3) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 40);
    cycle(0, 0, 0, 0);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit r, s, rv;
      int tgt;
      halt_cycles = (m_st == 2) ? halt_cycles + 1 : 0;
      r   = ($urandom_range(0, 99) < 2) || (halt_cycles > 4);
      s   = ($urandom_range(0, 99) < 25);
      rv  = ($urandom_range(0, 99) < 10);
      tgt = $urandom_range(0, 40);
      cycle(r, s, rv, tgt);
    end
    cycle(0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
